// File: rtl/key_bank.sv
// Multi-slot key store: word-serial atomic slot loads with sticky lock, registered full-width reads.
// Read latency 1 cycle, back-to-back reads allowed; no backpressure, illegal commands are dropped with an err pulse.
module key_bank #(
  parameter int KEY_W = 128,
  parameter int WORD_W = 32,
  parameter int NUM_SLOTS = 4,
  parameter logic [KEY_W-1:0] DEFAULT_KEY = 128'h6265657062656570606574747563652e,
  localparam int WPK = KEY_W / WORD_W,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load_start,
  input  logic [SW-1:0]     load_slot,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              abort,
  input  logic              lock,
  input  logic              rd_req,
  input  logic [SW-1:0]     rd_slot,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              locked,
  output logic              err
);

  localparam int CW = $clog2(WPK + 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(WPK - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nx;
  logic [CW-1:0]    r_count;
  logic [KEY_W-1:0] r_stage;
  logic [SW-1:0]    r_tgt;
  logic [KEY_W-1:0] r_slots [NUM_SLOTS];
  logic [KEY_W-1:0] r_key_out;
  logic             r_key_valid;
  logic             r_locked;
  logic             r_err;

  logic w_ld_in_range;
  logic w_rd_in_range;
  logic w_start_ok;
  logic w_shift;
  logic w_abort;
  logic w_commit;
  logic w_ld_err;
  logic w_rd_ok;
  logic w_rd_err;

  assign w_ld_in_range = int'(load_slot) < NUM_SLOTS;
  assign w_rd_in_range = int'(rd_slot) < NUM_SLOTS;
  assign w_rd_ok       = rd_req & w_rd_in_range;
  assign w_rd_err      = rd_req & ~w_rd_in_range;

  always_comb begin
    w_state_nx = r_state;
    w_start_ok = 1'b0;
    w_shift    = 1'b0;
    w_abort    = 1'b0;
    w_commit   = 1'b0;
    w_ld_err   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          if (!r_locked && w_ld_in_range) begin
            w_start_ok = 1'b1;
            w_state_nx = S_LOAD;
          end else begin
            w_ld_err = 1'b1;
          end
        end
        // A word arriving alongside an accepted start is silently dropped.
        if (wr_en && !w_start_ok) w_ld_err = 1'b1;
      end
      S_LOAD: begin
        if (load_start) w_ld_err = 1'b1;
        if (abort) begin
          w_abort    = 1'b1;
          w_state_nx = S_IDLE;
        end else if (wr_en) begin
          w_shift = 1'b1;
          if (r_count == LAST_WORD) w_state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit   = 1'b1;
        w_state_nx = S_IDLE;
        if (load_start || wr_en) w_ld_err = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_stage <= '0;
      r_tgt   <= '0;
    end else begin
      if (w_start_ok || w_abort || w_commit) begin
        r_count <= '0;
      end else if (w_shift) begin
        r_count <= r_count + CW'(1);
      end
      if (w_shift) r_stage <= {r_stage[KEY_W-WORD_W-1:0], wr_data};
      if (w_start_ok) r_tgt <= load_slot;
    end
  end

  // Read uses the pre-commit slot contents, so a read at the commit edge sees the old key.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) r_slots[i] <= DEFAULT_KEY;
      r_key_out   <= '0;
      r_key_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_commit) r_slots[r_tgt] <= r_stage;
      if (w_rd_ok) r_key_out <= r_slots[rd_slot];
      r_key_valid <= w_rd_ok;
      r_locked    <= r_locked | lock;
      r_err       <= w_ld_err | w_rd_err;
    end
  end

  assign key_out   = r_key_out;
  assign key_valid = r_key_valid;
  assign busy      = (r_state != S_IDLE);
  assign locked    = r_locked;
  assign err       = r_err;

endmodule

// File: tb/tb_key_bank.sv
// Bench for key_bank: directed scenarios with literal expectations, then random traffic against a queue-based model.
module tb_key_bank;

  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  localparam int NUM_SLOTS = 3;
  localparam int WPK = KEY_W / WORD_W;
  localparam int SW = 2;
  localparam logic [KEY_W-1:0] DEF = 128'h6265657062656570606574747563652e;
  localparam logic [KEY_W-1:0] NEWKEY = 128'h00112233445566778899aabbccddeeff;

  logic              clk = 1'b0;
  logic              n_rst = 1'b0;
  logic              load_start = 1'b0;
  logic [SW-1:0]     load_slot = '0;
  logic              wr_en = 1'b0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              abort = 1'b0;
  logic              lock = 1'b0;
  logic              rd_req = 1'b0;
  logic [SW-1:0]     rd_slot = '0;
  logic [KEY_W-1:0]  key_out;
  logic              key_valid;
  logic              busy;
  logic              locked;
  logic              err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_bank #(
    .KEY_W(KEY_W), .WORD_W(WORD_W), .NUM_SLOTS(NUM_SLOTS), .DEFAULT_KEY(DEF)
  ) dut (
    .clk(clk), .n_rst(n_rst), .load_start(load_start), .load_slot(load_slot),
    .wr_en(wr_en), .wr_data(wr_data), .abort(abort), .lock(lock),
    .rd_req(rd_req), .rd_slot(rd_slot), .key_out(key_out), .key_valid(key_valid),
    .busy(busy), .locked(locked), .err(err)
  );

  task automatic chk(input string nm, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: slot array, a word queue for the pending load, flags for load/commit phases.
  logic [KEY_W-1:0]  m_slot [NUM_SLOTS];
  logic [WORD_W-1:0] m_words [$];
  bit                m_active, m_commit_pend, m_locked, m_kv, m_err, m_e;
  int                m_tgt;
  logic [KEY_W-1:0]  m_kout, m_key;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) m_slot[i] = DEF;
      m_words.delete();
      m_active = 0; m_commit_pend = 0; m_locked = 0; m_kv = 0; m_err = 0;
      m_tgt = 0; m_kout = '0;
    end else begin
      m_e = 0;
      m_kv = 0;
      if (rd_req) begin
        if (int'(rd_slot) < NUM_SLOTS) begin
          m_kout = m_slot[rd_slot];
          m_kv = 1;
        end else m_e = 1;
      end
      if (m_commit_pend) begin
        m_key = '0;
        foreach (m_words[i]) m_key = (m_key << WORD_W) | KEY_W'(m_words[i]);
        m_slot[m_tgt] = m_key;
        m_commit_pend = 0;
        if (load_start || wr_en) m_e = 1;
      end else if (m_active) begin
        if (load_start) m_e = 1;
        if (abort) begin
          m_active = 0;
          m_words.delete();
        end else if (wr_en) begin
          m_words.push_back(wr_data);
          if (m_words.size() == WPK) begin
            m_active = 0;
            m_commit_pend = 1;
          end
        end
      end else begin
        if (load_start && (m_locked || int'(load_slot) >= NUM_SLOTS)) m_e = 1;
        else if (load_start) begin
          m_active = 1;
          m_tgt = int'(load_slot);
          m_words.delete();
        end else if (wr_en) m_e = 1;
      end
      if (lock) m_locked = 1;
      m_err = m_e;
    end
  end

  always @(negedge clk) begin
    chk("key_out", key_out, m_kout);
    chk("key_valid", KEY_W'(key_valid), KEY_W'(m_kv));
    chk("busy", KEY_W'(busy), KEY_W'(m_active || m_commit_pend));
    chk("locked", KEY_W'(locked), KEY_W'(m_locked));
    chk("err", KEY_W'(err), KEY_W'(m_err));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put_word(input logic [WORD_W-1:0] w);
    wr_en = 1'b1; wr_data = w;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_load(input int s);
    load_start = 1'b1; load_slot = SW'(s);
    tick();
    load_start = 1'b0;
  endtask

  task automatic read_now(input int s);
    rd_req = 1'b1; rd_slot = SW'(s);
    tick();
    rd_req = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 n_rst = 1'b0;
    tick();
    tick();
    #1 n_rst = 1'b1;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    n_rst = 1'b1;
    tick();
    chk("rst key_out", key_out, '0);

    for (int s = 0; s < 4; s++) begin
      read_now(s);
      if (s < NUM_SLOTS) begin
        chk("dflt key", key_out, DEF);
        chk("dflt kv", KEY_W'(key_valid), 1);
      end else begin
        chk("oob err", KEY_W'(err), 1);
        chk("oob kv", KEY_W'(key_valid), 0);
        chk("oob hold", key_out, DEF);
      end
    end
    tick();
    chk("kv one cycle", KEY_W'(key_valid), 0);

    start_load(2);
    chk("busy load", KEY_W'(busy), 1);
    put_word(32'h00112233);
    put_word(32'h44556677);
    tick();
    put_word(32'h8899aabb);
    put_word(32'hccddeeff);
    chk("busy commit", KEY_W'(busy), 1);
    read_now(2);
    chk("busy done", KEY_W'(busy), 0);
    chk("commit-edge old", key_out, DEF);
    read_now(2);
    chk("new key", key_out, NEWKEY);
    read_now(1);
    chk("slot1 dflt", key_out, DEF);

    start_load(0);
    put_word(32'hdeadbeef);
    put_word(32'h01234567);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", KEY_W'(busy), 0);
    chk("abort no err", KEY_W'(err), 0);
    put_word(32'h55555555);
    chk("idle wr err", KEY_W'(err), 1);
    read_now(0);
    chk("slot0 after abort", key_out, DEF);

    start_load(1);
    load_start = 1'b1; load_slot = 2'd0;
    put_word(32'haaaa0001);
    load_start = 1'b0;
    chk("start in load err", KEY_W'(err), 1);
    chk("start in load busy", KEY_W'(busy), 1);
    lock = 1'b1;
    put_word(32'haaaa0002);
    lock = 1'b0;
    chk("locked rises", KEY_W'(locked), 1);
    put_word(32'haaaa0003);
    put_word(32'haaaa0004);
    tick();
    read_now(1);
    chk("locked load commits", key_out, 128'haaaa0001aaaa0002aaaa0003aaaa0004);
    start_load(2);
    chk("locked start err", KEY_W'(err), 1);
    chk("locked start busy", KEY_W'(busy), 0);

    pulse_reset();
    start_load(0);
    put_word(32'h11111111);
    put_word(32'h22222222);
    pulse_reset();
    chk("rst busy", KEY_W'(busy), 0);
    chk("rst locked", KEY_W'(locked), 0);
    chk("rst key_out2", key_out, '0);
    read_now(1);
    chk("rst slot1", key_out, DEF);
    read_now(2);
    chk("rst slot2", key_out, DEF);

    for (int c = 0; c < 4000; c++) begin
      load_start = ($urandom_range(0, 9) == 0);
      load_slot  = SW'($urandom_range(0, 3));
      wr_en      = ($urandom_range(0, 1) == 0);
      wr_data    = $urandom;
      abort      = ($urandom_range(0, 29) == 0);
      lock       = ($urandom_range(0, 399) == 0);
      rd_req     = ($urandom_range(0, 1) == 0);
      rd_slot    = SW'($urandom_range(0, 3));
      if (c % 700 == 699) begin
        load_start = 0; wr_en = 0; abort = 0; lock = 0; rd_req = 0;
        pulse_reset();
      end else begin
        tick();
      end
    end
    load_start = 0; wr_en = 0; abort = 0; lock = 0; rd_req = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_bank.md
# key_bank

Parametrised multi-slot key store for the cryptographic datapath. Every slot powers up holding the built-in master key. Any slot can be rewritten atomically, one word at a time over a narrow bus, until a sticky lock is applied. The cipher core reads a full-width key from a selected slot with a one-cycle registered read.

## Interface
- KEY_W, 128, key width in bits; must be WORD_W × WPK with WPK ≥ 2
- WORD_W, 32, load bus width
- NUM_SLOTS, 4, number of key slots (≥ 1)
- DEFAULT_KEY, 128'h6265657062656570606574747563652e, reset value of every slot
- Derived: WPK = KEY_W/WORD_W; SW = max(1, $clog2(NUM_SLOTS))
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- load_start  in  1  request to begin loading slot load_slot
- load_slot  in  SW  target slot, sampled with load_start
- wr_en  in  1  load word strobe
- wr_data  in  WORD_W  load word; first word is most significant
- abort  in  1  discard an in-progress load
- lock  in  1  sets sticky lock; blocks new loads until reset
- rd_req  in  1  read request
- rd_slot  in  SW  slot to read, sampled with rd_req
- key_out  out  KEY_W  registered key read data
- key_valid  out  1  one-cycle pulse, key_out updated
- busy  out  1  load in progress (LOAD or COMMIT)
- locked  out  1  sticky lock state
- err  out  1  one-cycle pulse on a rejected command

## Operation
- Reset: all slots = DEFAULT_KEY. key_out = 0. key_valid, busy, locked, err = 0. State = IDLE. Word count = 0. Staging register = 0. Reset mid-load discards the staged words.
- FSM states: IDLE, LOAD, COMMIT.
- IDLE + load_start, locked = 0, load_slot < NUM_SLOTS:
  - go to LOAD
  - latch the target slot
  - clear the word count
  - a wr_en in the same cycle is ignored without err
- IDLE + load_start when locked = 1 or load_slot ≥ NUM_SLOTS: err pulse, stay IDLE.
- LOAD + wr_en:
  - staging = {staging[KEY_W-WORD_W-1:0], wr_data}
  - count increments
  - on the WPK-th word, go to COMMIT
- LOAD + abort: return to IDLE, clear the count, no slot change, no err. abort has priority over wr_en. abort outside LOAD is ignored.
- COMMIT: write staging to the target slot, go to IDLE. Lasts exactly one cycle.
- load_start while busy: ignored, err pulse.
- wr_en in IDLE or COMMIT: ignored, err pulse.
- lock asserted during LOAD: the current load completes normally. Only later load_start commands are rejected.
- Read: rd_req with rd_slot < NUM_SLOTS loads key_out from the slot and pulses key_valid. Reads are accepted in every state.
- rd_req with rd_slot ≥ NUM_SLOTS: err pulse, key_out unchanged, no key_valid.
- key_out holds its value between reads.
- Simultaneous error sources in one cycle produce a single err pulse.

## Timing
- Read latency: rd_req sampled at edge k; key_out and key_valid valid after edge k. Back-to-back reads every cycle are supported.
- Read/commit collision: a read of the target slot at the COMMIT edge returns the old key. The new key is visible to reads sampled at the next edge or later. Loads are atomic: a read never returns a partially written key.
- Minimum load, accepted at edge 0:
  - busy = 1 after edge 0
  - words at edges 1..WPK
  - COMMIT write at edge WPK+1
  - busy = 0 after edge WPK+1
  - idle cycles between words are allowed
- locked rises after the first edge at which lock = 1. It falls only on reset.
- err and key_valid are single-cycle registered pulses.

## Test plan
- Reset, then read slots 0..3 -> each returns 128'h6265657062656570606574747563652e with key_valid for exactly one cycle, one cycle after rd_req.
- Load slot 2 with 32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff (one idle cycle between words 2 and 3) -> busy spans LOAD+COMMIT; a subsequent read of slot 2 returns 128'h00112233445566778899aabbccddeeff; slot 1 is still the default.
- Read slot 2 at the COMMIT edge -> returns the old value; a read on the next cycle returns the new value.
- Start a load of slot 0, send 2 words, assert abort -> busy drops, no err, slot 0 is still the default; a following wr_en produces an err pulse.
- Assert lock for one cycle, then load_start -> locked = 1, err pulse, busy stays 0. lock during an active load -> that load commits, the next load_start pulses err.
- Protocol faults: with NUM_SLOTS = 3, rd_slot = 3 -> err, key_out unchanged. load_start during LOAD -> err, load continues. n_rst low mid-load -> all outputs return to reset values, all slots return to the default key.
